// File: rtl/inst_fetch_unit_pkg.sv
// Shared widths, FSM state encoding and the prefetch entry layout for the fetch stage.
package inst_fetch_unit_pkg;

    localparam int INST_W = 24;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bus plus the core-facing instruction handshake.
interface inst_fetch_unit_if;
    import inst_fetch_unit_pkg::*;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic              imem_rsp_valid;
    logic [INST_W-1:0] imem_rsp_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, inst_ready
    );

endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// Prefetch FIFO of {pc, inst} entries; flush overrides any push or pop in the same cycle.
module inst_fetch_unit_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o,
    output fetch_entry_t           head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: credit-limited instruction-memory requests, prefetch buffering and
// redirect handling that flushes the buffer and drops responses to stale requests.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
    input logic               clk,
    input logic               rst,
    inst_fetch_unit_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    fetch_state_t      state_q;
    logic [ADDR_W-1:0] fpc_q;
    logic [ADDR_W-1:0] rpc_q;
    logic [CNT_W-1:0]  outstanding_q;
    logic [CNT_W-1:0]  discard_q;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    fetch_entry_t      fifo_head;
    fetch_entry_t      push_entry;

    logic [CNT_W:0]    inflight;
    logic              credit_ok;
    logic              req;
    logic              accept;
    logic              rsp;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  discard_d;

    // Buffered plus in-flight entries never exceed DEPTH, so a response always has a slot.
    assign inflight  = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign credit_ok = !fifo_full && (inflight < DEPTH_C);

    assign req    = (state_q == FETCH) && credit_ok && !bus.redirect;
    assign accept = req && bus.imem_ready;
    assign rsp    = bus.imem_rsp_valid;
    assign push   = rsp && !bus.redirect && (discard_q == '0);
    assign pop    = !fifo_empty && bus.inst_ready;

    // On redirect every request still in flight after this cycle's response is stale.
    assign discard_d = outstanding_q - CNT_W'(rsp);

    assign push_entry.pc   = rpc_q;
    assign push_entry.inst = bus.imem_rsp_data;

    inst_fetch_unit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (bus.redirect),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .head_o      (fifo_head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            fpc_q         <= RESET_PC;
            rpc_q         <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            case ({accept, rsp})
                2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase

            if (bus.redirect) begin
                fpc_q     <= bus.redirect_pc;
                rpc_q     <= bus.redirect_pc;
                discard_q <= discard_d;
                state_q   <= (discard_d != '0) ? DRAIN : FETCH;
            end else begin
                if (accept) begin
                    fpc_q <= fpc_q + PC_STEP;
                end
                if (rsp) begin
                    if (discard_q == '0) begin
                        rpc_q <= rpc_q + PC_STEP;
                    end else begin
                        discard_q <= discard_q - CNT_W'(1);
                    end
                end
                case (state_q)
                    IDLE:    state_q <= FETCH;
                    FETCH:   state_q <= FETCH;
                    DRAIN: begin
                        if ((discard_q == '0) || (rsp && (discard_q == CNT_W'(1)))) begin
                            state_q <= FETCH;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.imem_req   = req;
    assign bus.imem_addr  = fpc_q;
    assign bus.inst_valid = !fifo_empty;
    assign bus.inst       = fifo_empty ? '0 : fifo_head.inst;
    assign bus.inst_pc    = fifo_empty ? '0 : fifo_head.pc;

endmodule
